// File: rtl/cpu_cache_ctrl.sv
// Write-back, write-allocate controller between the CPU port, cpu_cache and mem_ctrl.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module cpu_cache_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req,
  input  logic         cpu_wr,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_done,
  output logic         cpu_busy,
  output logic         cache_en,
  output logic         cache_comp,
  output logic         cache_wr,
  output logic         cache_valid_in,
  output logic         cache_replaceLine,
  output logic [7:0]   cache_index,
  output logic [5:0]   cache_offset,
  output logic [17:0]  cache_tag_in,
  output logic [31:0]  cache_data_in,
  output logic [511:0] cache_cl_in,
  input  logic         cache_hit,
  input  logic         cache_dirty,
  input  logic         cache_valid,
  input  logic [17:0]  cache_tag_out,
  input  logic [31:0]  cache_data_out,
  input  logic [511:0] cache_cl_out,
  output logic         mem_rd_req,
  output logic         mem_wr_req,
  output logic [31:0]  mem_addr,
  output logic [511:0] mem_wr_data,
  input  logic [511:0] mem_rd_data,
  input  logic         mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses,
  output logic [31:0]  stat_wbs
`endif
);

  typedef enum logic [2:0] {
    StIdle, StCompare, StWrite, StWb, StFill, StFillWr, StDone
  } state_e;

  state_e         state_q, state_d;
  logic           wr_q, wr_d;
  logic [31:2]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [511:0]   mem_wr_data_q, mem_wr_data_d;
  logic [511:0]   line_q, line_d;
  logic           lookup_hit;

  // Byte-within-word bits carry no meaning for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      line_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      line_q        <= line_d;
    end
  end

  assign lookup_hit = cache_hit & cache_valid;

  always_comb begin
    state_d           = state_q;
    wr_d              = wr_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    mem_addr_d        = mem_addr_q;
    mem_wr_data_d     = mem_wr_data_q;
    line_d            = line_q;
    cache_en          = 1'b0;
    cache_comp        = 1'b0;
    cache_wr          = 1'b0;
    cache_valid_in    = 1'b0;
    cache_replaceLine = 1'b0;
    mem_rd_req        = 1'b0;
    mem_wr_req        = 1'b0;
    cpu_done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          wr_d    = cpu_wr;
          addr_d  = cpu_addr[31:2];
          wdata_d = cpu_wdata;
          state_d = StCompare;
        end
      end
      StCompare: begin
        cache_en   = 1'b1;
        cache_comp = 1'b1;
        if (lookup_hit) begin
          if (wr_q) begin
            state_d = StWrite;
          end else begin
            rdata_d = cache_data_out;
            state_d = StDone;
          end
        end else if (cache_valid && cache_dirty) begin
          mem_wr_data_d = cache_cl_out;
          mem_addr_d    = {cache_tag_out, addr_q[13:6], 6'b0};
          state_d       = StWb;
        end else begin
          mem_addr_d = {addr_q[31:6], 6'b0};
          state_d    = StFill;
        end
      end
      StWrite: begin
        cache_en   = 1'b1;
        cache_comp = 1'b1;
        cache_wr   = 1'b1;
        state_d    = StDone;
      end
      StWb: begin
        mem_wr_req = 1'b1;
        if (mem_ready) begin
          mem_addr_d = {addr_q[31:6], 6'b0};
          state_d    = StFill;
        end
      end
      StFill: begin
        mem_rd_req = 1'b1;
        if (mem_ready) begin
          line_d  = mem_rd_data;
          state_d = StFillWr;
        end
      end
      StFillWr: begin
        cache_en          = 1'b1;
        cache_replaceLine = 1'b1;
        cache_valid_in    = 1'b1;
        // Retry the lookup; the freshly installed line always hits.
        state_d           = StCompare;
      end
      StDone: begin
        cpu_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_busy      = (state_q != StIdle);
  assign cpu_rdata     = rdata_q;
  assign cache_index   = addr_q[13:6];
  assign cache_tag_in  = addr_q[31:14];
  assign cache_offset  = {addr_q[5:2], 2'b00};
  assign cache_data_in = wdata_q;
  assign cache_cl_in   = line_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;

`ifdef CACHE_STATS_EN
  logic        first_q, first_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic [31:0] wbs_q, wbs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q  <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      first_q  <= first_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  // Only the first lookup of an access is counted, not the post-fill retry.
  always_comb begin
    first_d  = first_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    if (state_q == StIdle && cpu_req) begin
      first_d = 1'b1;
    end
    if (state_q == StCompare) begin
      first_d = 1'b0;
      if (first_q) begin
        if (lookup_hit) begin
          if (hits_q != '1) hits_d = hits_q + 32'd1;
        end else begin
          if (misses_q != '1) misses_d = misses_q + 32'd1;
        end
      end
    end
    if (state_q == StWb && mem_ready && wbs_q != '1) begin
      wbs_d = wbs_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbs    = wbs_q;
`endif

endmodule
